// File: rtl/io_ctrl_if.sv
// CPU-side address and strobe bundle for the memory-mapped I/O controller.
// The shared data bus stays a plain inout on the controller.
interface io_ctrl_if;
    logic [15:0] addresses;
    logic        oe;
    logic        io_re;

    modport master (output addresses, output oe, output io_re);
    modport slave  (input  addresses, input  oe, input  io_re);
endinterface

// File: rtl/io_ctrl.sv
// Memory-mapped I/O controller: two output ports, two synchronized input ports,
// a prescaled down-counting timer and level interrupts for timer expiry and IN0[0] rising edges.
module io_ctrl #(
    parameter logic [15:0] BASE     = 16'hFF00,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    io_ctrl_if.slave    bus,
    inout  wire  [15:0] data_inout,
    input  logic [15:0] in_port0,
    input  logic [15:0] in_port1,
    output logic [15:0] out_port0,
    output logic [15:0] out_port1,
    output logic [7:0]  int_req
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    localparam logic [3:0] A_OUT0   = 4'h0;
    localparam logic [3:0] A_OUT1   = 4'h1;
    localparam logic [3:0] A_IN0    = 4'h2;
    localparam logic [3:0] A_IN1    = 4'h3;
    localparam logic [3:0] A_TLOAD  = 4'h4;
    localparam logic [3:0] A_TCTRL  = 4'h5;
    localparam logic [3:0] A_TCOUNT = 4'h6;
    localparam logic [3:0] A_STATUS = 4'h7;

    logic [15:0]   out0, out1, tload, tcount;
    logic          t_en, t_auto, t_tie, t_eie;
    logic          st_texp, st_edge;
    logic [PW-1:0] presc;
    logic [15:0]   sync0_a, sync0_b, sync1_a, sync1_b;
    logic          edge_prev;

    logic          hit, wr, rd;
    logic [3:0]    sel;
    logic [15:0]   wdata, rdata;
    logic          wr_tctrl, start, stop, tick, expire, edge_set;
    logic [1:0]    w1c;

    assign sel   = bus.addresses[3:0];
    assign hit   = (bus.addresses[15:4] == BASE[15:4]);
    assign wr    = bus.oe && hit;
    assign rd    = bus.io_re && !bus.oe && hit;
    assign wdata = data_inout;

    // A TCTRL write with EN=0 takes priority over a tick landing in the same cycle.
    assign wr_tctrl = wr && (sel == A_TCTRL);
    assign start    = wr_tctrl && wdata[0] && !t_en;
    assign stop     = wr_tctrl && !wdata[0];
    assign tick     = t_en && !stop && (presc == PRESC_LAST);
    assign expire   = tick && (tcount == 16'd0);
    assign edge_set = sync0_b[0] && !edge_prev;
    assign w1c      = (wr && (sel == A_STATUS)) ? wdata[1:0] : 2'b00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out0      <= '0;
            out1      <= '0;
            tload     <= '0;
            tcount    <= '0;
            t_en      <= 1'b0;
            t_auto    <= 1'b0;
            t_tie     <= 1'b0;
            t_eie     <= 1'b0;
            st_texp   <= 1'b0;
            st_edge   <= 1'b0;
            presc     <= '0;
            sync0_a   <= '0;
            sync0_b   <= '0;
            sync1_a   <= '0;
            sync1_b   <= '0;
            edge_prev <= 1'b0;
        end else begin
            sync0_a   <= in_port0;
            sync0_b   <= sync0_a;
            sync1_a   <= in_port1;
            sync1_b   <= sync1_a;
            edge_prev <= sync0_b[0];

            if (!t_en || stop || tick) presc <= '0;
            else                       presc <= presc + PW'(1);

            if (start) begin
                tcount <= tload;
            end else if (tick) begin
                if (tcount != 16'd0) tcount <= tcount - 16'd1;
                else if (t_auto)     tcount <= tload;
            end

            if (wr_tctrl) begin
                t_en   <= wdata[0];
                t_auto <= wdata[1];
                t_tie  <= wdata[2];
                t_eie  <= wdata[3];
            end else if (expire && !t_auto) begin
                t_en <= 1'b0;
            end

            // Hardware set wins over a same-cycle software clear.
            st_texp <= (st_texp && !w1c[0]) || expire;
            st_edge <= (st_edge && !w1c[1]) || edge_set;

            if (wr && (sel == A_OUT0))  out0  <= wdata;
            if (wr && (sel == A_OUT1))  out1  <= wdata;
            if (wr && (sel == A_TLOAD)) tload <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        case (sel)
            A_OUT0:   rdata = out0;
            A_OUT1:   rdata = out1;
            A_IN0:    rdata = sync0_b;
            A_IN1:    rdata = sync1_b;
            A_TLOAD:  rdata = tload;
            A_TCTRL:  rdata = {12'd0, t_eie, t_tie, t_auto, t_en};
            A_TCOUNT: rdata = tcount;
            A_STATUS: rdata = {14'd0, st_edge, st_texp};
            default:  rdata = '0;
        endcase
    end

    assign data_inout = (rd && reset) ? rdata : 16'bz;
    assign out_port0  = out0;
    assign out_port1  = out1;
    assign int_req    = {6'd0, st_edge && t_eie, st_texp && t_tie};

endmodule

// File: tb/tb_io_ctrl.sv
// Directed bench for io_ctrl: a register-level model of the I/O block is stepped every
// clock and compared against the DUT each cycle, plus hand-computed literal checks.
module tb_io_ctrl;

    localparam int PRESCALE = 1;
    localparam logic [15:0] A_OUT0   = 16'hFF00;
    localparam logic [15:0] A_OUT1   = 16'hFF01;
    localparam logic [15:0] A_IN0    = 16'hFF02;
    localparam logic [15:0] A_IN1    = 16'hFF03;
    localparam logic [15:0] A_TLOAD  = 16'hFF04;
    localparam logic [15:0] A_TCTRL  = 16'hFF05;
    localparam logic [15:0] A_TCOUNT = 16'hFF06;
    localparam logic [15:0] A_STATUS = 16'hFF07;

    logic        clk;
    logic        reset;
    logic [15:0] in_port0, in_port1;
    logic [15:0] out_port0, out_port1;
    logic [7:0]  int_req;
    logic [15:0] tb_data;
    logic        tb_drv;
    wire  [15:0] data_inout;

    int n_checks = 0;
    int n_errors = 0;

    io_ctrl_if bus ();

    io_ctrl #(.BASE(16'hFF00), .PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .data_inout (data_inout),
        .in_port0   (in_port0),
        .in_port1   (in_port1),
        .out_port0  (out_port0),
        .out_port1  (out_port1),
        .int_req    (int_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic hit(input logic [15:0] a);
        return a[15:4] == 12'hFF0;
    endfunction

    // The bench drives the bus whenever the DUT must not, so any stray DUT drive disturbs it.
    assign tb_drv     = !(reset && bus.io_re && !bus.oe && hit(bus.addresses));
    assign data_inout = tb_drv ? tb_data : 16'bz;

    // Model state: the software-visible registers plus pin history.
    logic [15:0] m_out0, m_out1, m_tload, m_count;
    logic        m_en, m_auto, m_tie, m_eie, m_texp, m_edge;
    int          m_phase;
    logic [15:0] m_p0_d1, m_p0_d2, m_p1_d1, m_p1_d2;
    logic        m_p0_d3;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_out0 = 0; m_out1 = 0; m_tload = 0; m_count = 0;
        m_en = 0; m_auto = 0; m_tie = 0; m_eie = 0; m_texp = 0; m_edge = 0;
        m_phase = 0;
        m_p0_d1 = 0; m_p0_d2 = 0; m_p0_d3 = 0; m_p1_d1 = 0; m_p1_d2 = 0;
    endtask

    function automatic logic [15:0] m_read(input logic [3:0] s);
        case (s)
            4'h0: return m_out0;
            4'h1: return m_out1;
            4'h2: return m_p0_d2;
            4'h3: return m_p1_d2;
            4'h4: return m_tload;
            4'h5: return {12'd0, m_eie, m_tie, m_auto, m_en};
            4'h6: return m_count;
            4'h7: return {14'd0, m_edge, m_texp};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_step();
        logic wr, start, stop, texp_set, edge_set;
        logic [3:0] s;
        logic [15:0] d;
        wr = bus.oe && hit(bus.addresses);
        s = bus.addresses[3:0];
        d = tb_data;
        start = wr && s == 4'h5 && d[0] && !m_en;
        stop = wr && s == 4'h5 && !d[0];
        texp_set = 1'b0;
        edge_set = m_p0_d2[0] && !m_p0_d3;
        if (start) begin
            m_count = m_tload;
            m_phase = 0;
        end else if (m_en && !stop) begin
            if (m_phase == PRESCALE - 1) begin
                m_phase = 0;
                if (m_count != 0) m_count = m_count - 1;
                else begin
                    texp_set = 1'b1;
                    if (m_auto) m_count = m_tload;
                    else m_en = 1'b0;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end else begin
            m_phase = 0;
        end
        m_texp = (m_texp && !(wr && s == 4'h7 && d[0])) || texp_set;
        m_edge = (m_edge && !(wr && s == 4'h7 && d[1])) || edge_set;
        if (wr) begin
            case (s)
                4'h0: m_out0 = d;
                4'h1: m_out1 = d;
                4'h4: m_tload = d;
                4'h5: begin m_en = d[0]; m_auto = d[1]; m_tie = d[2]; m_eie = d[3]; end
                default: ;
            endcase
        end
        m_p0_d3 = m_p0_d2[0];
        m_p0_d2 = m_p0_d1;
        m_p0_d1 = in_port0;
        m_p1_d2 = m_p1_d1;
        m_p1_d1 = in_port1;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    task automatic compare_cycle();
        check("out_port0", out_port0, m_out0);
        check("out_port1", out_port1, m_out1);
        check("int_req", {8'd0, int_req}, {14'd0, m_edge && m_eie, m_texp && m_tie});
        if (reset && bus.io_re && !bus.oe && hit(bus.addresses))
            check("bus_read", data_inout, m_read(bus.addresses[3:0]));
        else
            check("bus_released", data_inout, tb_data);
    endtask

    task automatic drive(input logic [15:0] a, input logic o, input logic r, input logic [15:0] d);
        bus.addresses = a;
        bus.oe = o;
        bus.io_re = r;
        tb_data = o ? d : 16'h0000;
    endtask

    task automatic finish_cycle();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        if (reset) model_step();
        else model_clear();
        #1;
    endtask

    task automatic cyc(input logic [15:0] a, input logic o, input logic r, input logic [15:0] d);
        drive(a, o, r, d);
        finish_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(16'h0000, 1'b0, 1'b0, 16'h0000);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        cyc(a, 1'b1, 1'b0, d);
    endtask

    task automatic rd_lit(input logic [15:0] a, input logic [15:0] exp, input string name);
        drive(a, 1'b0, 1'b1, 16'h0000);
        #1;
        check(name, data_inout, exp);
        finish_cycle();
    endtask

    initial begin
        logic [15:0] exp_cnt [5];
        logic        exp_irq [5];
        exp_cnt = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd3};
        exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset then idle
        reset = 1'b0;
        in_port0 = 16'h0000;
        in_port1 = 16'h0000;
        drive(16'h0000, 1'b0, 1'b0, 16'h0000);
        model_clear();
        #3;
        check("rst_out_port0", out_port0, 16'h0000);
        check("rst_int_req", {8'd0, int_req}, 16'h0000);
        repeat (3) finish_cycle();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) rd_lit(16'hFF00 + 16'(i), 16'h0000, "rst_read");
        idle(1);

        // Port write/read and decode boundaries
        wr(A_OUT0, 16'hA5A5);
        check("out0_after_store", out_port0, 16'hA5A5);
        in_port1 = 16'h1234;
        idle(2);
        rd_lit(A_IN1, 16'h1234, "in1_read");
        rd_lit(A_OUT0, 16'hA5A5, "out0_read");
        wr(A_OUT1, 16'h0F0F);
        rd_lit(A_OUT1, 16'h0F0F, "out1_read");
        wr(16'hFE00, 16'hFFFF);
        check("miss_write", out_port0, 16'hA5A5);
        wr(16'hFF08, 16'h7777);
        rd_lit(16'hFF08, 16'h0000, "unmapped_read8");
        rd_lit(16'hFF0A, 16'h0000, "unmapped_readA");
        cyc(A_OUT1, 1'b1, 1'b1, 16'h3C3C);
        check("oe_and_re_write", out_port1, 16'h3C3C);
        cyc(16'h0010, 1'b0, 1'b1, 16'h0000);

        // Auto-reload timer, TLOAD=3
        wr(A_TLOAD, 16'd3);
        wr(A_TCTRL, 16'h0007);
        for (int i = 0; i < 5; i++) begin
            drive(A_TCOUNT, 1'b0, 1'b1, 16'h0000);
            #1;
            check("auto_tcount", data_inout, exp_cnt[i]);
            check("auto_irq0", {15'd0, int_req[0]}, {15'd0, exp_irq[i]});
            finish_cycle();
        end
        wr(A_STATUS, 16'h0001);
        check("w1c_irq0_drop", {8'd0, int_req}, 16'h0000);
        idle(1);
        check("irq0_still_low", {8'd0, int_req}, 16'h0000);
        idle(1);
        check("irq0_reassert", {8'd0, int_req}, 16'h0001);
        idle(3);
        wr(A_STATUS, 16'h0001);
        check("set_beats_clear", {8'd0, int_req}, 16'h0001);
        wr(A_STATUS, 16'h0001);
        check("clear_after_collision", {8'd0, int_req}, 16'h0000);
        wr(A_TCTRL, 16'h0000);

        // One-shot timer, TLOAD=2
        wr(A_TLOAD, 16'd2);
        wr(A_TCTRL, 16'h0005);
        idle(3);
        check("oneshot_irq0", {8'd0, int_req}, 16'h0001);
        rd_lit(A_TCTRL, 16'h0004, "oneshot_en_cleared");
        rd_lit(A_TCOUNT, 16'h0000, "oneshot_tcount0");
        idle(2);
        rd_lit(A_TCOUNT, 16'h0000, "oneshot_tcount_held");
        wr(A_STATUS, 16'h0001);

        // Stop with count held, then restart reloads
        wr(A_TLOAD, 16'd6);
        wr(A_TCTRL, 16'h0003);
        idle(2);
        wr(A_TCTRL, 16'h0002);
        rd_lit(A_TCOUNT, 16'd4, "stop_held");
        idle(1);
        rd_lit(A_TCOUNT, 16'd4, "stop_still_held");
        wr(A_TCTRL, 16'h0003);
        rd_lit(A_TCOUNT, 16'd6, "restart_reload");
        wr(A_TCTRL, 16'h0000);
        wr(A_STATUS, 16'h0003);

        // Edge interrupt on IN0[0]
        wr(A_TCTRL, 16'h0008);
        in_port0 = 16'h0001;
        idle(2);
        check("edge_not_yet", {8'd0, int_req}, 16'h0000);
        idle(1);
        check("edge_3rd_edge", {8'd0, int_req}, 16'h0002);
        rd_lit(A_IN0, 16'h0001, "in0_read");
        idle(3);
        wr(A_STATUS, 16'h0002);
        check("edge_w1c", {8'd0, int_req}, 16'h0002 & 16'h0000);
        idle(4);
        check("edge_no_retrigger", {8'd0, int_req}, 16'h0000);
        in_port0 = 16'h0000;
        idle(4);
        in_port0 = 16'h8001;
        idle(3);
        check("edge_again", {8'd0, int_req}, 16'h0002);
        rd_lit(A_STATUS, 16'h0002, "status_edge");
        wr(A_STATUS, 16'h0002);
        wr(A_TCTRL, 16'h0000);
        in_port0 = 16'h0000;
        idle(4);

        // Reset mid-count
        wr(A_OUT1, 16'h1111);
        wr(A_TLOAD, 16'd5);
        wr(A_TCTRL, 16'h0007);
        idle(2);
        rd_lit(A_TCOUNT, 16'd3, "pre_reset_tcount");
        drive(16'h0000, 1'b0, 1'b0, 16'h0000);
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        check("async_rst_out1", out_port1, 16'h0000);
        check("async_rst_int", {8'd0, int_req}, 16'h0000);
        finish_cycle();
        finish_cycle();
        reset = 1'b1;
        idle(8);
        check("post_rst_int", {8'd0, int_req}, 16'h0000);
        rd_lit(A_STATUS, 16'h0000, "post_rst_status");
        rd_lit(A_TCTRL, 16'h0000, "post_rst_tctrl");
        rd_lit(A_TCOUNT, 16'h0000, "post_rst_tcount");
        rd_lit(A_OUT1, 16'h0000, "post_rst_out1");
        idle(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
